// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bundle: decoder-side operand/producer info in, stall/forward/MDU status out.
// Combinational response within the cycle; the decoder holds D while stall is high.
interface hazard_scoreboard_if #(
   parameter int TW = 2,
   parameter int SW = 2
);
   logic          d_valid;
   logic [4:0]    d_rs;
   logic [4:0]    d_rt;
   logic [TW-1:0] d_tuse_rs;
   logic [TW-1:0] d_tuse_rt;
   logic [TW-1:0] d_tnew;
   logic [4:0]    d_dst;
   logic          d_md_start;
   logic          d_md_div;
   logic          d_md_use;
   logic          flush;
   logic          stall;
   logic [SW-1:0] fwd_rs_sel;
   logic [SW-1:0] fwd_rt_sel;
   logic          md_busy;

   modport master (
      output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_tnew, d_dst,
             d_md_start, d_md_div, d_md_use, flush,
      input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_tnew, d_dst,
             d_md_start, d_md_div, d_md_use, flush,
      output stall, fwd_rs_sel, fwd_rt_sel, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew stall and forward controller plus MDU busy counter; stall/forward are same-cycle combinational.
// Stages after D never stall: slots advance every cycle, a stalled D injects a bubble into slot 1.
module hazard_scoreboard #(
   parameter int STAGES      = 3,
   parameter int TW          = 2,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int SW          = $clog2(STAGES + 1)
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave bus
);

   typedef struct packed {
      logic          valid;
      logic [4:0]    dst;
      logic [TW-1:0] tnew;
   } slot_t;

   typedef struct packed {
      logic          hit;
      logic [SW-1:0] stage;
      logic [TW-1:0] tnew;
   } match_t;

   slot_t      slot [1:STAGES];
   logic [7:0] md_cnt;

   match_t m_rs;
   match_t m_rt;
   logic   rs_stall;
   logic   rt_stall;
   logic   md_stall;
   logic   accept;

   // Scanning oldest to youngest lets the youngest producer win.
   function automatic match_t lookup(input logic [4:0] src);
      match_t m;
      m = '0;
      for (int k = STAGES; k >= 1; k--) begin
         if (src != 5'd0 && slot[k].valid && slot[k].dst == src) begin
            m.hit   = 1'b1;
            m.stage = SW'(k);
            m.tnew  = slot[k].tnew;
         end
      end
      return m;
   endfunction

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   always_comb begin
      m_rs = lookup(bus.d_rs);
      m_rt = lookup(bus.d_rt);
   end

   assign rs_stall = m_rs.hit && (bus.d_tuse_rs != '1) && (m_rs.tnew > bus.d_tuse_rs);
   assign rt_stall = m_rt.hit && (bus.d_tuse_rt != '1) && (m_rt.tnew > bus.d_tuse_rt);
   assign md_stall = bus.d_valid && bus.d_md_use && bus.md_busy;

   assign bus.stall      = bus.d_valid && (rs_stall || rt_stall || md_stall);
   assign bus.fwd_rs_sel = (m_rs.hit && m_rs.tnew == '0) ? m_rs.stage : '0;
   assign bus.fwd_rt_sel = (m_rt.hit && m_rt.tnew == '0) ? m_rt.stage : '0;
   assign bus.md_busy    = (md_cnt != 8'd0);

   assign accept = bus.d_valid && !bus.stall && !bus.flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k <= STAGES; k++) begin
            slot[k] <= '0;
         end
         md_cnt <= 8'd0;
      end else begin
         if (accept) begin
            slot[1] <= slot_t'{valid: 1'b1, dst: bus.d_dst, tnew: bus.d_tnew};
         end else begin
            slot[1] <= '0;
         end

         for (int k = 2; k <= STAGES; k++) begin
            if (bus.flush) begin
               slot[k] <= '0;
            end else begin
               slot[k].valid <= slot[k-1].valid;
               slot[k].dst   <= slot[k-1].dst;
               slot[k].tnew  <= sat_dec(slot[k-1].tnew);
            end
         end

         // An MD operation already issued keeps counting through a flush.
         if (accept && bus.d_md_start) begin
            md_cnt <= bus.d_md_div ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
         end else if (md_cnt != 8'd0) begin
            md_cnt <= md_cnt - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU forwarding, youngest-match, $0, MDU busy, flush, reset.
module tb_hazard_scoreboard;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   n;

   hazard_scoreboard_if #(.TW(2), .SW(2)) bus ();

   hazard_scoreboard #(
      .STAGES(3), .TW(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .SW(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                        input logic [4:0] rt, input logic [1:0] trt, input logic [4:0] dst,
                        input logic [1:0] tnew, input logic ms, input logic md, input logic mu);
      bus.d_valid    = v;
      bus.d_rs       = rs;
      bus.d_tuse_rs  = trs;
      bus.d_rt       = rt;
      bus.d_tuse_rt  = trt;
      bus.d_dst      = dst;
      bus.d_tnew     = tnew;
      bus.d_md_start = ms;
      bus.d_md_div   = md;
      bus.d_md_use   = mu;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b0;
      bus.flush = 1'b0;

      // Reset held with a live instruction in D
      drive(1'b1, 5'd5, 2'd0, 5'd0, 2'd3, 5'd5, 2'd2, 1'b1, 1'b1, 1'b1);
      #2;
      check("reset_stall", 32'(bus.stall), 32'd0);
      check("reset_fwd_rs", 32'(bus.fwd_rs_sel), 32'd0);
      check("reset_busy", 32'(bus.md_busy), 32'd0);
      tick();
      tick();
      check("reset_hold_stall", 32'(bus.stall), 32'd0);
      check("reset_hold_busy", 32'(bus.md_busy), 32'd0);
      idle();
      #2;
      reset = 1'b1;
      #1;
      drive(1'b1, 5'd5, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("post_reset_stall", 32'(bus.stall), 32'd0);
      check("post_reset_fwd_rs", 32'(bus.fwd_rs_sel), 32'd0);
      check("post_reset_fwd_rt", 32'(bus.fwd_rt_sel), 32'd0);
      tick();

      // lw $8 then beq on $8: two stall cycles, then forward from W
      drive(1'b1, 5'd1, 2'd3, 5'd2, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      #1;
      check("lw_issue_stall", 32'(bus.stall), 32'd0);
      tick();
      drive(1'b1, 5'd8, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("beq_stall_c1", 32'(bus.stall), 32'd1);
      check("beq_fwd_c1", 32'(bus.fwd_rs_sel), 32'd0);
      tick();
      check("beq_stall_c2", 32'(bus.stall), 32'd1);
      tick();
      check("beq_stall_c3", 32'(bus.stall), 32'd0);
      check("beq_fwd_w", 32'(bus.fwd_rs_sel), 32'd3);
      tick();

      // addu $9 then consumers with tuse 1 and tuse 0
      drive(1'b1, 5'd1, 2'd1, 5'd2, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      check("addu_p_stall", 32'(bus.stall), 32'd0);
      tick();
      drive(1'b1, 5'd9, 2'd1, 5'd3, 2'd1, 5'd11, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      check("addu_c_stall", 32'(bus.stall), 32'd0);
      check("addu_c_fwd_rs", 32'(bus.fwd_rs_sel), 32'd0);
      tick();
      drive(1'b1, 5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("m_fwd_stall", 32'(bus.stall), 32'd0);
      check("m_fwd_rs", 32'(bus.fwd_rs_sel), 32'd2);
      drive(1'b1, 5'd9, 2'd0, 5'd11, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("rt_tuse1_stall", 32'(bus.stall), 32'd0);
      check("rt_tuse1_fwd", 32'(bus.fwd_rt_sel), 32'd0);
      drive(1'b1, 5'd9, 2'd0, 5'd11, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("rt_tuse0_stall", 32'(bus.stall), 32'd1);
      idle();
      tick();
      tick();
      tick();

      // Producer with tnew 0 forwards straight from E
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd0, 2'd3, 5'd12, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("e_fwd_rt", 32'(bus.fwd_rt_sel), 32'd1);
      check("e_fwd_stall", 32'(bus.stall), 32'd0);
      idle();
      tick();
      tick();
      tick();

      // Two producers of $10: older still pending, younger ready
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd10, 2'd0, 5'd10, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("young_stall", 32'(bus.stall), 32'd0);
      check("young_fwd_rs", 32'(bus.fwd_rs_sel), 32'd1);
      check("young_fwd_rt", 32'(bus.fwd_rt_sel), 32'd1);

      // Write to $0 never matches
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("zero_stall", 32'(bus.stall), 32'd0);
      check("zero_fwd_rs", 32'(bus.fwd_rs_sel), 32'd0);
      idle();
      tick();
      tick();
      tick();

      // div then mflo: 10 stall cycles
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      #1;
      check("div_issue_busy", 32'(bus.md_busy), 32'd0);
      tick();
      check("div_busy_next", 32'(bus.md_busy), 32'd1);
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1);
      #1;
      n = 0;
      while (bus.stall && n < 40) begin
         n++;
         tick();
      end
      check("mflo_div_stall_cycles", 32'(n), 32'd10);
      check("div_busy_done", 32'(bus.md_busy), 32'd0);
      tick();

      // mult then mfhi: 5 stall cycles
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1);
      #1;
      n = 0;
      while (bus.stall && n < 40) begin
         n++;
         tick();
      end
      check("mfhi_mult_stall_cycles", 32'(n), 32'd5);
      idle();
      tick();
      tick();
      tick();

      // Flush with lw in E, dependent stalled in D, mult counting
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 5'd1, 2'd3, 5'd2, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      check("flush_pre_stall", 32'(bus.stall), 32'd1);
      bus.flush = 1'b1;
      #1;
      check("flush_stall_unmasked", 32'(bus.stall), 32'd1);
      tick();
      bus.flush = 1'b0;
      #1;
      check("flush_after_stall", 32'(bus.stall), 32'd0);
      check("flush_after_fwd", 32'(bus.fwd_rs_sel), 32'd0);
      check("flush_busy_kept", 32'(bus.md_busy), 32'd1);
      idle();
      n = 0;
      while (bus.md_busy && n < 40) begin
         n++;
         tick();
      end
      check("flush_busy_remaining", 32'(n), 32'd3);

      // A flushed MD instruction must not start the counter
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      idle();
      #1;
      check("flush_no_md_load", 32'(bus.md_busy), 32'd0);

      // Reset mid-operation aborts busy count and in-flight producers
      drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd1, 2'd3, 5'd2, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      #1;
      check("pre_reset_stall", 32'(bus.stall), 32'd1);
      reset = 1'b0;
      #1;
      check("midreset_stall", 32'(bus.stall), 32'd0);
      check("midreset_busy", 32'(bus.md_busy), 32'd0);
      reset = 1'b1;
      #1;
      check("after_midreset_stall", 32'(bus.stall), 32'd0);
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
